btb_set_assoc: RTL and testbench

BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

---
 rtl/btb_pkg.sv | 34 +++
 rtl/btb_lru_set.sv | 52 +++++
 rtl/btb_set_assoc.sv | 144 ++++++++++++++
 tb/tb_btb_set_assoc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and PC field helpers for the set-associative BTB.
// Optional macro BTB_HYST_EN adds a per-entry confidence bit.
package btb_pkg;

    localparam int PC_W  = 32;
    // Widest tag occurs at the smallest set count (2 sets -> 1 index bit).
    localparam int TAG_W = PC_W - 2 - 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
`ifdef BTB_HYST_EN
        logic             conf;
`endif
    } btb_entry_t;

    function automatic logic [PC_W-1:0] btb_index(
        input logic [PC_W-1:0] pc,
        input int unsigned     iw
    );
        return (pc >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(
        input logic [PC_W-1:0] pc,
        input int unsigned     iw
    );
        logic [PC_W-1:0] t;
        t = pc >> (iw + 32'd2);
        return t[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/btb_lru_set.sv
// True-LRU age vector for one BTB set.
// Age 0 is most recent; the way holding age WAYS-1 is the victim.
module btb_lru_set #(
    parameter int WAYS = 4,
    parameter int AW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          touch_i,
    input  logic [AW-1:0] touch_way_i,
    output logic [AW-1:0] victim_o
);

    logic [AW-1:0] age_q [WAYS];
    logic [AW-1:0] age_d [WAYS];
    logic [AW-1:0] tage;

    // Touched way becomes age 0; younger ways age by one.
    always_comb begin
        age_d = age_q;
        tage  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == touch_way_i) tage = age_q[w];
        end
        if (touch_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == touch_way_i)
                    age_d[w] = '0;
                else if (age_q[w] < tage)
                    age_d[w] = age_q[w] + 1'b1;
            end
        end
    end

    // Oldest way is the replacement candidate.
    always_comb begin
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[w] == AW'(WAYS - 1)) victim_o = AW'(w);
        end
    end

    // Age register; reset gives way w age w.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= AW'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer, multi-slot zero-latency lookup.
// Define BTB_HYST_EN for target-replacement hysteresis.
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int SETS  = 16,
    parameter int WAYS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      lookup_valid,
    input  logic [WIDTH-1:0][31:0] lookup_pc,
    output logic [WIDTH-1:0]      hit,
    output logic [WIDTH-1:0][31:0] target,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic [31:0]           update_target,
    output logic                  mismatch,
    input  logic                  flush_all
);

    localparam int IW = $clog2(SETS);
    localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] FT_STEP = 32'(4 * WIDTH);
    localparam logic [31:0] FT_MASK = ~(FT_STEP - 32'd1);

    btb_entry_t ent_q [SETS][WAYS];
    btb_entry_t ent_d [SETS][WAYS];

    logic [AW-1:0]    victim [SETS];
    logic [SETS-1:0]  touch;
    logic [IW-1:0]    uidx;
    logic [TAG_W-1:0] utag;
    logic             uhit;
    logic             any_free;
    logic [AW-1:0]    uway;
    logic [AW-1:0]    free_way;
    logic [AW-1:0]    sel_way;

    assign uidx = IW'(btb_index(update_pc, IW));
    assign utag = btb_tag(update_pc, IW);

    // Per-slot lookup against current contents, fall-through on miss.
    always_comb begin
        hit    = '0;
        target = '0;
        for (int k = 0; k < WIDTH; k++) begin
            target[k] = (lookup_pc[k] & FT_MASK) + FT_STEP;
            for (int w = 0; w < WAYS; w++) begin
                if (lookup_valid[k]
                    && ent_q[IW'(btb_index(lookup_pc[k], IW))][w].valid
                    && ent_q[IW'(btb_index(lookup_pc[k], IW))][w].tag
                       == btb_tag(lookup_pc[k], IW)) begin
                    hit[k]    = 1'b1;
                    target[k] = ent_q[IW'(btb_index(lookup_pc[k], IW))][w].target;
                end
            end
        end
    end

    // Update-side tag match, free-way search and way selection.
    always_comb begin
        uhit     = 1'b0;
        uway     = '0;
        any_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ent_q[uidx][w].valid && ent_q[uidx][w].tag == utag) begin
                uhit = 1'b1;
                uway = AW'(w);
            end
            if (!ent_q[uidx][w].valid) begin
                any_free = 1'b1;
                free_way = AW'(w);
            end
        end
        sel_way  = uhit ? uway : (any_free ? free_way : victim[uidx]);
        mismatch = update_valid
                 && (!uhit || ent_q[uidx][uway].target != update_target);
    end

    // Next entry contents; flush wins over a same-cycle update.
    always_comb begin
        ent_d = ent_q;
        if (flush_all) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    ent_d[s][w].valid = 1'b0;
        end else if (update_valid) begin
            if (uhit) begin
`ifdef BTB_HYST_EN
                if (ent_q[uidx][sel_way].target == update_target) begin
                    ent_d[uidx][sel_way].conf = 1'b1;
                end else if (ent_q[uidx][sel_way].conf) begin
                    ent_d[uidx][sel_way].conf = 1'b0;
                end else begin
                    ent_d[uidx][sel_way].target = update_target;
                    ent_d[uidx][sel_way].conf   = 1'b0;
                end
`else
                ent_d[uidx][sel_way].target = update_target;
`endif
            end else begin
                ent_d[uidx][sel_way].valid  = 1'b1;
                ent_d[uidx][sel_way].tag    = utag;
                ent_d[uidx][sel_way].target = update_target;
`ifdef BTB_HYST_EN
                ent_d[uidx][sel_way].conf   = 1'b0;
`endif
            end
        end
    end

    // Only an accepted update refreshes recency of its set.
    always_comb begin
        for (int s = 0; s < SETS; s++)
            touch[s] = update_valid && !flush_all && (uidx == IW'(s));
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    ent_q[s][w] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        btb_lru_set #(
            .WAYS (WAYS)
        ) u_lru (
            .clock       (clock),
            .reset       (reset),
            .touch_i     (touch[s]),
            .touch_way_i (sel_way),
            .victim_o    (victim[s])
        );
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomized self-checking bench for btb_set_assoc (2 slots, 16 sets, 4 ways).
// Honors BTB_HYST_EN when defined.
module tb_btb_set_assoc;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       lookup_valid;
    logic [1:0][31:0] lookup_pc;
    logic [1:0]       hit;
    logic [1:0][31:0] target;
    logic             update_valid;
    logic [31:0]      update_pc;
    logic [31:0]      update_target;
    logic             mismatch;
    logic             flush_all;

    always #5 clock = ~clock;

    btb_set_assoc #(.WIDTH(2), .SETS(16), .WAYS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .hit           (hit),
        .target        (target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .mismatch      (mismatch),
        .flush_all     (flush_all)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: per set, a bag of entries with last-touch timestamps.
    bit          mv   [16][4];
    logic [25:0] mtag [16][4];
    logic [31:0] mtgt [16][4];
    bit          mconf[16][4];
    int unsigned mst  [16][4];
    int unsigned now_t = 0;

    function automatic void m_clear();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
    endfunction

    function automatic void m_look(input logic [31:0] pc, output bit h,
                                   output logic [31:0] t);
        int s;
        s = int'(pc[5:2]);
        h = 1'b0;
        t = (pc & 32'hFFFF_FFF8) + 32'd8;
        for (int w = 0; w < 4; w++) begin
            if (mv[s][w] && mtag[s][w] == pc[31:6]) begin
                h = 1'b1;
                t = mtgt[s][w];
            end
        end
    endfunction

    function automatic void m_upd(input logic [31:0] pc, input logic [31:0] tg);
        int s;
        int slot;
        s = int'(pc[5:2]);
        now_t++;
        for (int w = 0; w < 4; w++) begin
            if (mv[s][w] && mtag[s][w] == pc[31:6]) begin
`ifdef BTB_HYST_EN
                if (mtgt[s][w] == tg) mconf[s][w] = 1'b1;
                else if (mconf[s][w]) mconf[s][w] = 1'b0;
                else mtgt[s][w] = tg;
`else
                mtgt[s][w] = tg;
`endif
                mst[s][w] = now_t;
                return;
            end
        end
        slot = -1;
        for (int w = 0; w < 4; w++)
            if (!mv[s][w] && slot < 0) slot = w;
        if (slot < 0) begin
            slot = 0;
            for (int w = 1; w < 4; w++)
                if (mst[s][w] < mst[s][slot]) slot = w;
        end
        mv[s][slot]    = 1'b1;
        mtag[s][slot]  = pc[31:6];
        mtgt[s][slot]  = tg;
        mconf[s][slot] = 1'b0;
        mst[s][slot]   = now_t;
    endfunction

    task automatic probe(input string tag, input logic [31:0] pc,
                         input logic eh, input logic [31:0] et);
        lookup_valid = 2'b01;
        lookup_pc[0] = pc;
        #1;
        check({tag, "_hit"}, 32'(hit[0]), 32'(eh));
        check({tag, "_tgt"}, target[0], et);
    endtask

    task automatic step(input logic [1:0] lv, input logic [31:0] p0,
                        input logic [31:0] p1, input logic uv,
                        input logic [31:0] up, input logic [31:0] ut,
                        input logic fl);
        bit          h;
        logic [31:0] t;
        lookup_valid  = lv;
        lookup_pc[0]  = p0;
        lookup_pc[1]  = p1;
        update_valid  = uv;
        update_pc     = up;
        update_target = ut;
        flush_all     = fl;
        #2;
        for (int k = 0; k < 2; k++) begin
            m_look(k == 0 ? p0 : p1, h, t);
            check($sformatf("hit%0d", k), 32'(hit[k]), 32'(lv[k] & h));
            if (lv[k]) check($sformatf("tgt%0d", k), target[k], t);
        end
        m_look(up, h, t);
        check("mis", 32'(mismatch), 32'(uv && (!h || t != ut)));
        @(posedge clock);
        if (fl) m_clear();
        else if (uv) m_upd(up, ut);
        #1;
        update_valid = 1'b0;
        flush_all    = 1'b0;
    endtask

    function automatic logic [31:0] rpc();
        return 32'h1000 | (32'($urandom_range(0, 7)) << 6)
                        | (32'($urandom_range(0, 3)) << 2)
                        | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        reset         = 1'b1;
        lookup_valid  = '0;
        lookup_pc     = '0;
        update_valid  = 1'b1;
        update_pc     = 32'h1000;
        update_target = 32'h2000;
        flush_all     = 1'b0;
        m_clear();
        probe("rst", 32'h1000, 1'b0, 32'h1008);
        check("rst_mis", 32'(mismatch), 32'd1);
        update_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        probe("r33a", 32'h1000, 1'b0, 32'h1008);
        probe("r33b", 32'h1004, 1'b0, 32'h1008);

        update_valid  = 1'b1;
        update_pc     = 32'h1000;
        update_target = 32'h2000;
        probe("r34_same", 32'h1000, 1'b0, 32'h1008);
        check("r34_mis", 32'(mismatch), 32'd1);
        step(2'b01, 32'h1000, 32'h0, 1'b1, 32'h1000, 32'h2000, 1'b0);
        probe("r34_next", 32'h1000, 1'b1, 32'h2000);

        step(2'b00, 0, 0, 1'b1, 32'h1000, 32'h2000, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h1040, 32'h5040, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h1080, 32'h5080, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h10C0, 32'h50C0, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h1100, 32'h5100, 1'b0);
        probe("r35_1000", 32'h1000, 1'b0, 32'h1008);
        probe("r35_1040", 32'h1040, 1'b1, 32'h5040);
        probe("r35_1080", 32'h1080, 1'b1, 32'h5080);
        probe("r35_10c0", 32'h10C0, 1'b1, 32'h50C0);
        probe("r35_1100", 32'h1100, 1'b1, 32'h5100);

        step(2'b00, 0, 0, 1'b1, 32'h1200, 32'h6200, 1'b1);
        probe("r36_1200", 32'h1200, 1'b0, 32'h1208);
        probe("r36_1040", 32'h1040, 1'b0, 32'h1048);
        probe("r36_1100", 32'h1100, 1'b0, 32'h1108);

        step(2'b00, 0, 0, 1'b1, 32'h1000, 32'h2000, 1'b0);
        step(2'b00, 0, 0, 1'b1, 32'h1000, 32'h2000, 1'b0);
        update_valid  = 1'b1;
        update_pc     = 32'h1000;
        update_target = 32'h3000;
        #1;
        check("r37_mis", 32'(mismatch), 32'd1);
        step(2'b00, 0, 0, 1'b1, 32'h1000, 32'h3000, 1'b0);
`ifdef BTB_HYST_EN
        probe("r37_a", 32'h1000, 1'b1, 32'h2000);
`else
        probe("r37_a", 32'h1000, 1'b1, 32'h3000);
`endif
        step(2'b00, 0, 0, 1'b1, 32'h1000, 32'h3000, 1'b0);
        probe("r37_b", 32'h1000, 1'b1, 32'h3000);

        update_valid  = 1'b1;
        update_pc     = 32'h1300;
        update_target = 32'h4000;
        #1;
        reset = 1'b1;
        #1;
        check("r38_hit", 32'(hit[0]), 32'd0);
        check("r38_tgt", target[0], 32'h1008);
        check("r38_mis", 32'(mismatch), 32'd1);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        update_valid = 1'b0;
        m_clear();
        probe("r28_1300", 32'h1300, 1'b0, 32'h1308);
        probe("r28_1000", 32'h1000, 1'b0, 32'h1008);
        step(2'b00, 0, 0, 1'b0, 0, 0, 1'b0);

        repeat (400) begin
            step(2'($urandom), rpc(), rpc(), 1'($urandom_range(0, 1)),
                 rpc(), 32'h2000 + (32'($urandom_range(0, 3)) << 4),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
